// File: rtl/host_cycle_bridge_m_if.sv
// CPU-side request/acknowledge bus between the CPU core and host_cycle_bridge_m.
interface host_cycle_bridge_m_if;
    logic        cpu_req;
    logic [23:0] cpu_adr;
    logic        cpu_rnw;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;

    modport master (output cpu_req, cpu_adr, cpu_rnw, cpu_wdata, input cpu_ack, cpu_rdata);
    modport slave  (input cpu_req, cpu_adr, cpu_rnw, cpu_wdata, output cpu_ack, cpu_rdata);
endinterface

// File: rtl/host_cycle_bridge_m.sv
// Decodes CPU requests into on-board RAM, local register or BBC host-bus cycles,
// with ROM/RAM remapping, a pagereg mirror, GPIO and an IO-access holdoff pipe.
module host_cycle_bridge_m #(
    parameter int GPIO_SZ            = 2,
    parameter int IO_ACCESS_DELAY_SZ = 3,
    parameter int RAM_ADR_SZ         = 19,
    parameter int PHI0_SYNC_STAGES   = 2
) (
    input  logic                   hsclk,
    input  logic                   resetb,
    host_cycle_bridge_m_if.slave   cpu,
    output logic                   cpu_hs_ok,
    output logic                   ram_ceb,
    output logic                   ram_web,
    output logic [RAM_ADR_SZ-17:0] ram_adr,
    input  logic                   bbc_phi0,
    output logic [15:0]            bbc_adr,
    output logic                   bbc_rnw,
    output logic [7:0]             bbc_data_out,
    output logic                   bbc_data_oe,
    input  logic [7:0]             bbc_data_in,
    output logic [GPIO_SZ-1:0]     gpio_out,
    output logic [GPIO_SZ-1:0]     gpio_oe,
    input  logic [GPIO_SZ-1:0]     gpio_in
);
    localparam int BANK_W = RAM_ADR_SZ - 16;

    typedef enum logic [2:0] {S_IDLE, S_RAM, S_REG, S_H_WAIT, S_H_HIGH} state_t;

    state_t                        state_q, state_d;
    logic                          ack_q, ack_d;
    logic [7:0]                    rdata_q, rdata_d;
    logic                          hs_ok_q, hs_ok_d;
    logic                          ram_ceb_q, ram_ceb_d;
    logic                          ram_web_q, ram_web_d;
    logic [BANK_W-1:0]             ram_adr_q, ram_adr_d;
    logic [15:0]                   bbc_adr_q, bbc_adr_d;
    logic                          bbc_rnw_q, bbc_rnw_d;
    logic [7:0]                    bbc_data_out_q, bbc_data_out_d;
    logic                          bbc_data_oe_q, bbc_data_oe_d;
    logic [GPIO_SZ-1:0]            gpio_dir_q, gpio_dir_d;
    logic [GPIO_SZ-1:0]            gpio_data_q, gpio_data_d;
    logic [6:0]                    map_q, map_d;
    logic [3:0]                    pagereg_q, pagereg_d;
    logic [IO_ACCESS_DELAY_SZ-1:0] pipe_q, pipe_d;
    logic [PHI0_SYNC_STAGES-1:0]   phi0_sync_q, phi0_sync_d;
    logic                          phi0_last_q, phi0_last_d;

    logic [23:0] adr;
    logic [7:0]  remap_bank;
    logic        phi0_rise, phi0_fall, remap, io_access, host_ack, host_next;
    logic        unused_adr_bits;

    assign adr             = cpu.cpu_adr;
    assign remap_bank      = 8'hFE;
    assign unused_adr_bits = ^adr;

    always_comb begin
        state_d        = state_q;
        ack_d          = 1'b0;
        rdata_d        = rdata_q;
        ram_adr_d      = ram_adr_q;
        gpio_dir_d     = gpio_dir_q;
        gpio_data_d    = gpio_data_q;
        map_d          = map_q;
        pagereg_d      = pagereg_q;
        pipe_d         = pipe_q;
        host_ack       = 1'b0;

        phi0_sync_d = {phi0_sync_q[PHI0_SYNC_STAGES-2:0], bbc_phi0};
        phi0_last_d = phi0_sync_q[PHI0_SYNC_STAGES-1];
        phi0_rise   = phi0_sync_q[PHI0_SYNC_STAGES-1] & ~phi0_last_q;
        phi0_fall   = ~phi0_sync_q[PHI0_SYNC_STAGES-1] & phi0_last_q;

        // Lower-64K remaps into RAM bank 0xFE: low RAM, ROM area outside the IO page, paged ROM slot 15
        remap = ~adr[23] & ((map_q[4] & ~adr[15])
              | (map_q[5] & (adr[15:14] == 2'b11) & (adr[13:10] != 4'hF))
              | (map_q[5] & (adr[15:14] == 2'b10) & (pagereg_q == 4'hF)));
        io_access = (adr[15:10] == 6'h3F);

        case (state_q)
            S_IDLE: begin
                if (cpu.cpu_req) begin
                    if ((adr[23:22] == 2'b11) || remap) begin
                        state_d   = S_RAM;
                        ram_adr_d = remap ? remap_bank[BANK_W-1:0] : adr[RAM_ADR_SZ-1:16];
                    end else if (adr[23:22] == 2'b10) begin
                        state_d = S_REG;
                    end else begin
                        state_d = S_H_WAIT;
                    end
                end
            end
            S_RAM: begin
                state_d = S_IDLE;
                ack_d   = 1'b1;
            end
            S_REG: begin
                state_d = S_IDLE;
                ack_d   = 1'b1;
                if (cpu.cpu_rnw) begin
                    case (adr[1:0])
                        2'b00:   rdata_d = 8'(gpio_dir_q);
                        2'b01:   rdata_d = 8'(gpio_in);
                        2'b11:   rdata_d = {1'b0, map_q};
                        default: rdata_d = 8'h00;
                    endcase
                end else begin
                    case (adr[1:0])
                        2'b00:   gpio_dir_d  = cpu.cpu_wdata[GPIO_SZ-1:0];
                        2'b01:   gpio_data_d = cpu.cpu_wdata[GPIO_SZ-1:0];
                        2'b11:   map_d       = cpu.cpu_wdata[6:0];
                        default: ;
                    endcase
                end
            end
            S_H_WAIT: begin
                if (phi0_rise) state_d = S_H_HIGH;
            end
            S_H_HIGH: begin
                if (phi0_fall) begin
                    state_d  = S_IDLE;
                    ack_d    = 1'b1;
                    host_ack = 1'b1;
                    // bbc_data_in is sampled every H_HIGH cycle; the sample at this edge is the last one
                    if (cpu.cpu_rnw) rdata_d = bbc_data_in;
                    if (!cpu.cpu_rnw && (adr == 24'h00FE30)) pagereg_d = cpu.cpu_wdata[3:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ack_d) pipe_d = (host_ack && io_access) ? '1 : (pipe_q >> 1);
        hs_ok_d = map_q[6] & (pipe_q == '0);

        host_next      = (state_d == S_H_WAIT) || (state_d == S_H_HIGH);
        bbc_adr_d      = host_next ? adr[15:0] : 16'h8000;
        bbc_rnw_d      = host_next ? cpu.cpu_rnw : 1'b1;
        bbc_data_oe_d  = (state_d == S_H_HIGH) & ~cpu.cpu_rnw;
        bbc_data_out_d = host_next ? cpu.cpu_wdata : bbc_data_out_q;
        ram_ceb_d      = (state_d != S_RAM);
        ram_web_d      = (state_d == S_RAM) ? cpu.cpu_rnw : 1'b1;
    end

    always_ff @(posedge hsclk) begin
        if (!resetb) begin
            state_q        <= S_IDLE;
            ack_q          <= 1'b0;
            rdata_q        <= 8'h00;
            hs_ok_q        <= 1'b0;
            ram_ceb_q      <= 1'b1;
            ram_web_q      <= 1'b1;
            ram_adr_q      <= '0;
            bbc_adr_q      <= 16'h8000;
            bbc_rnw_q      <= 1'b1;
            bbc_data_out_q <= 8'h00;
            bbc_data_oe_q  <= 1'b0;
            gpio_dir_q     <= '0;
            gpio_data_q    <= '0;
            map_q          <= '0;
            pagereg_q      <= '0;
            pipe_q         <= '0;
            phi0_sync_q    <= '0;
            phi0_last_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ack_q          <= ack_d;
            rdata_q        <= rdata_d;
            hs_ok_q        <= hs_ok_d;
            ram_ceb_q      <= ram_ceb_d;
            ram_web_q      <= ram_web_d;
            ram_adr_q      <= ram_adr_d;
            bbc_adr_q      <= bbc_adr_d;
            bbc_rnw_q      <= bbc_rnw_d;
            bbc_data_out_q <= bbc_data_out_d;
            bbc_data_oe_q  <= bbc_data_oe_d;
            gpio_dir_q     <= gpio_dir_d;
            gpio_data_q    <= gpio_data_d;
            map_q          <= map_d;
            pagereg_q      <= pagereg_d;
            pipe_q         <= pipe_d;
            phi0_sync_q    <= phi0_sync_d;
            phi0_last_q    <= phi0_last_d;
        end
    end

    assign cpu.cpu_ack   = ack_q;
    assign cpu.cpu_rdata = rdata_q;
    assign cpu_hs_ok     = hs_ok_q;
    assign ram_ceb       = ram_ceb_q;
    assign ram_web       = ram_web_q;
    assign ram_adr       = ram_adr_q;
    assign bbc_adr       = bbc_adr_q;
    assign bbc_rnw       = bbc_rnw_q;
    assign bbc_data_out  = bbc_data_out_q;
    assign bbc_data_oe   = bbc_data_oe_q;
    assign gpio_oe       = gpio_dir_q;
    assign gpio_out      = gpio_data_q;
endmodule

// File: tb/tb_host_cycle_bridge_m.sv
// Randomised bench for host_cycle_bridge_m against an address-map level reference model.
module tb_host_cycle_bridge_m;
    localparam int GPIO_SZ            = 2;
    localparam int IO_ACCESS_DELAY_SZ = 3;
    localparam int RAM_ADR_SZ         = 19;
    localparam int PHI0_SYNC_STAGES   = 2;
    localparam int BANK_W             = RAM_ADR_SZ - 16;
    localparam int HALF_CYC           = 16;
    localparam int K_RAM = 0, K_REG = 1, K_HOST = 2;

    logic                   hsclk = 1'b0;
    logic                   resetb = 1'b0;
    logic                   bbc_phi0 = 1'b0;
    logic                   cpu_hs_ok, ram_ceb, ram_web;
    logic [BANK_W-1:0]      ram_adr;
    logic [15:0]            bbc_adr;
    logic                   bbc_rnw, bbc_data_oe;
    logic [7:0]             bbc_data_out;
    logic [7:0]             bbc_data_in = 8'h00;
    logic [GPIO_SZ-1:0]     gpio_out, gpio_oe;
    logic [GPIO_SZ-1:0]     gpio_in = '0;

    host_cycle_bridge_m_if cpu_if();

    host_cycle_bridge_m #(
        .GPIO_SZ(GPIO_SZ), .IO_ACCESS_DELAY_SZ(IO_ACCESS_DELAY_SZ),
        .RAM_ADR_SZ(RAM_ADR_SZ), .PHI0_SYNC_STAGES(PHI0_SYNC_STAGES)
    ) dut (
        .hsclk(hsclk), .resetb(resetb), .cpu(cpu_if), .cpu_hs_ok(cpu_hs_ok),
        .ram_ceb(ram_ceb), .ram_web(ram_web), .ram_adr(ram_adr),
        .bbc_phi0(bbc_phi0), .bbc_adr(bbc_adr), .bbc_rnw(bbc_rnw),
        .bbc_data_out(bbc_data_out), .bbc_data_oe(bbc_data_oe), .bbc_data_in(bbc_data_in),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .gpio_in(gpio_in)
    );

    int n_vec = 0;
    int n_err = 0;
    int unsigned edge_cnt = 0;
    int unsigned fall_edge = 0;

    // reference model state
    logic [6:0]         m_map;
    logic [3:0]         m_page;
    logic [GPIO_SZ-1:0] m_dir, m_data;
    int                 m_hold;

    always #5 hsclk = ~hsclk;
    always @(posedge hsclk) edge_cnt <= edge_cnt + 1;

    // phi0: period 32 hsclk, edges kept away from hsclk edges and sample points
    initial begin
        #3;
        forever begin
            #(HALF_CYC * 10) bbc_phi0 = 1'b1;
            #(HALF_CYC * 10) bbc_phi0 = 1'b0;
            fall_edge = edge_cnt;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hsclk);
        #1;
    endtask

    task automatic model_reset();
        m_map  = '0;
        m_page = '0;
        m_dir  = '0;
        m_data = '0;
        m_hold = 0;
    endtask

    function automatic int model_kind(input logic [23:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        if (a[23:22] == 2'b11) return K_RAM;
        if (a[23:22] == 2'b10) return K_REG;
        if (m_map[4] && lo < 16'h8000) return K_RAM;
        if (m_map[5] && lo >= 16'hC000 && lo < 16'hFC00) return K_RAM;
        if (m_map[5] && lo >= 16'h8000 && lo < 16'hC000 && m_page == 4'd15) return K_RAM;
        return K_HOST;
    endfunction

    task automatic run_txn(input logic [23:0] adr, input logic rnw, input logic [7:0] wdata,
                           input logic [7:0] din, input logic [GPIO_SZ-1:0] gin);
        int kind, cycles, ceb_cycles, oe_cycles;
        logic [7:0] fe, rd_e;
        logic [BANK_W-1:0] bank_e, bank_seen;
        logic web_seen;
        bit bus_ok, acked;

        kind = model_kind(adr);
        fe = 8'hFE;
        bank_e = (adr[23:22] == 2'b11) ? adr[RAM_ADR_SZ-1:16] : fe[BANK_W-1:0];
        rd_e = 8'h00;
        if (kind == K_HOST) rd_e = din;
        else if (kind == K_REG) begin
            if (adr[1:0] == 2'd0) rd_e = 8'(m_dir);
            else if (adr[1:0] == 2'd1) rd_e = 8'(gin);
            else if (adr[1:0] == 2'd3) rd_e = {1'b0, m_map};
        end

        cycles = 0; ceb_cycles = 0; oe_cycles = 0;
        bank_seen = '0; web_seen = 1'b1; bus_ok = 1; acked = 0;
        gpio_in = gin;
        bbc_data_in = din;
        cpu_if.cpu_adr = adr;
        cpu_if.cpu_rnw = rnw;
        cpu_if.cpu_wdata = wdata;
        cpu_if.cpu_req = 1'b1;
        while (!acked && cycles < 200) begin
            tick();
            cycles++;
            if (cpu_if.cpu_ack) acked = 1;
            else begin
                if (!ram_ceb) begin
                    ceb_cycles++;
                    bank_seen = ram_adr;
                    web_seen = ram_web;
                end
                if (bbc_data_oe) begin
                    oe_cycles++;
                    if (bbc_data_out !== wdata) bus_ok = 0;
                end
                if (kind == K_HOST) begin
                    if (bbc_adr !== adr[15:0] || bbc_rnw !== rnw) bus_ok = 0;
                end else if (bbc_adr !== 16'h8000 || bbc_rnw !== 1'b1 || bbc_data_oe !== 1'b0) bus_ok = 0;
            end
        end
        cpu_if.cpu_req = 1'b0;

        check_val("ack_seen", acked, 1);
        check_val("bus_drive", bus_ok, 1);
        if (kind == K_HOST) begin
            check_val("host_ceb", ceb_cycles, 0);
            check_val("phi0_lag", edge_cnt - fall_edge, PHI0_SYNC_STAGES + 1);
            check_val("oe_cycles", oe_cycles, rnw ? 0 : HALF_CYC);
        end else begin
            check_val("latency", cycles, 2);
            check_val("ceb_cycles", ceb_cycles, (kind == K_RAM) ? 1 : 0);
            if (kind == K_RAM) begin
                check_val("ram_bank", bank_seen, bank_e);
                check_val("ram_web", web_seen, rnw);
            end
        end
        if (rnw && kind != K_RAM) check_val("rdata", cpu_if.cpu_rdata, rd_e);

        if (kind == K_REG && !rnw) begin
            if (adr[1:0] == 2'd0) m_dir = wdata[GPIO_SZ-1:0];
            if (adr[1:0] == 2'd1) m_data = wdata[GPIO_SZ-1:0];
            if (adr[1:0] == 2'd3) m_map = wdata[6:0];
        end
        if (kind == K_HOST && !rnw && adr == 24'h00FE30) m_page = wdata[3:0];
        if (kind == K_HOST && adr[15:0] >= 16'hFC00) m_hold = IO_ACCESS_DELAY_SZ;
        else if (m_hold > 0) m_hold--;

        tick();
        check_val("ack_pulse", cpu_if.cpu_ack, 0);
        tick();
        check_val("gpio_oe", gpio_oe, m_dir);
        check_val("gpio_out", gpio_out, m_data);
        check_val("hs_ok", cpu_hs_ok, (m_map[6] && m_hold == 0) ? 1 : 0);
    endtask

    task automatic check_reset_outputs();
        check_val("rst_ack", cpu_if.cpu_ack, 0);
        check_val("rst_rdata", cpu_if.cpu_rdata, 0);
        check_val("rst_hs_ok", cpu_hs_ok, 0);
        check_val("rst_ram_ceb", ram_ceb, 1);
        check_val("rst_ram_web", ram_web, 1);
        check_val("rst_ram_adr", ram_adr, 0);
        check_val("rst_bbc_adr", bbc_adr, 16'h8000);
        check_val("rst_bbc_rnw", bbc_rnw, 1);
        check_val("rst_bbc_oe", bbc_data_oe, 0);
        check_val("rst_bbc_dout", bbc_data_out, 0);
        check_val("rst_gpio_oe", gpio_oe, 0);
        check_val("rst_gpio_out", gpio_out, 0);
    endtask

    initial begin
        int waited;
        logic [23:0] a;
        logic rnw;
        logic [7:0] wd;
        int r;

        cpu_if.cpu_req = 1'b0;
        cpu_if.cpu_adr = 24'h0;
        cpu_if.cpu_rnw = 1'b1;
        cpu_if.cpu_wdata = 8'h00;
        model_reset();
        repeat (3) tick();
        check_reset_outputs();
        resetb = 1'b1;
        repeat (5) tick();

        run_txn(24'h800003, 1'b0, 8'h40, 8'h00, 2'b00);   // map = hsclk_en
        run_txn(24'hC12345, 1'b1, 8'h00, 8'h11, 2'b00);
        run_txn(24'h001234, 1'b1, 8'h00, 8'h5A, 2'b00);
        run_txn(24'h800003, 1'b0, 8'h30, 8'h00, 2'b00);
        run_txn(24'h00FE30, 1'b0, 8'h0F, 8'h00, 2'b00);
        run_txn(24'h008000, 1'b1, 8'h00, 8'h22, 2'b00);
        run_txn(24'h00FC00, 1'b1, 8'h00, 8'h33, 2'b00);
        run_txn(24'h001000, 1'b1, 8'h00, 8'h44, 2'b00);
        run_txn(24'h800003, 1'b0, 8'h40, 8'h00, 2'b00);
        run_txn(24'h00FE40, 1'b1, 8'h00, 8'hA5, 2'b00);
        for (int i = 0; i < 3; i++) run_txn(24'hC00000, 1'b1, 8'h00, 8'h00, 2'b00);
        run_txn(24'h800000, 1'b0, 8'h01, 8'h00, 2'b00);
        run_txn(24'h800001, 1'b0, 8'h03, 8'h00, 2'b00);
        run_txn(24'h800001, 1'b1, 8'h00, 8'h00, 2'b10);
        run_txn(24'h800003, 1'b1, 8'h00, 8'h00, 2'b00);
        run_txn(24'h800002, 1'b1, 8'h00, 8'h00, 2'b11);

        // reset in the middle of a host write aborts it without ack
        run_txn(24'h800003, 1'b0, 8'h00, 8'h00, 2'b00);
        cpu_if.cpu_adr = 24'h002000;
        cpu_if.cpu_rnw = 1'b0;
        cpu_if.cpu_wdata = 8'hC3;
        cpu_if.cpu_req = 1'b1;
        waited = 0;
        while (!bbc_data_oe && waited < 100) begin
            tick();
            waited++;
        end
        check_val("abort_oe_reached", bbc_data_oe, 1);
        resetb = 1'b0;
        tick();
        check_val("abort_oe_drop", bbc_data_oe, 0);
        check_val("abort_no_ack", cpu_if.cpu_ack, 0);
        cpu_if.cpu_req = 1'b0;
        tick();
        check_reset_outputs();
        resetb = 1'b1;
        model_reset();
        repeat (5) tick();

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            rnw = 1'($urandom_range(0, 1));
            wd = 8'($urandom);
            if (r < 2) a = {2'b11, 22'($urandom)};
            else if (r < 4) a = {2'b10, 22'($urandom)};
            else if (r == 4) begin
                a = 24'h00FE30;
                rnw = 1'b0;
            end else if (r == 5) a = {8'h00, 6'h3F, 10'($urandom)};
            else a = {8'h00, 16'($urandom)};
            run_txn(a, rnw, wd, 8'($urandom), GPIO_SZ'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/host_cycle_bridge_m.md
# host_cycle_bridge_m

Synchronous, parametrised successor to the level-1b glue for the hsclk-based core. It decodes each CPU bus request into on-board RAM, internal register, or BBC host-bus cycles. For host-bus cycles it synchronises to bbc_phi0 and runs one complete host cycle before acknowledging. It also carries the ROM/RAM remap logic, a mirror of the ROM page register, GPIO of configurable width, and a configurable IO-access holdoff pipe that gates high-speed operation.

## Interface
Parameters:
- GPIO_SZ, 2, number of GPIO pins
- IO_ACCESS_DELAY_SZ, 3, holdoff depth in completed CPU cycles after a host IO access
- RAM_ADR_SZ, 19, on-board RAM address width; the block drives bits [RAM_ADR_SZ-1:16]
- PHI0_SYNC_STAGES, 2, bbc_phi0 synchroniser depth (minimum 2)

Ports:
- hsclk  in  1  sole clock, all state on rising edge
- resetb  in  1  reset, synchronous, active-low
- bbc_phi0  in  1  asynchronous host clock
- cpu_req  in  1  request valid; held until cpu_ack
- cpu_adr  in  24  request address
- cpu_rnw  in  1  1 = read
- cpu_wdata  in  8  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data, valid with cpu_ack, held until next ack
- cpu_hs_ok  out  1  high-speed clocking permitted
- ram_ceb, ram_web  out  1  RAM strobes, active-low
- ram_adr  out  RAM_ADR_SZ-16  RAM bank bits
- bbc_adr  out  16  host address
- bbc_rnw  out  1  host read/write
- bbc_data_out  out  8  host write data
- bbc_data_oe  out  1  host data drive enable
- bbc_data_in  in  8  host read data
- gpio_out, gpio_oe  out  GPIO_SZ  pin value and per-pin drive enable
- gpio_in  in  GPIO_SZ  pin state

## Operation
Decode is evaluated in IDLE when cpu_req=1, then registered:
- cpu_adr[23:22]=11: RAM cycle.
- cpu_adr[23:22]=10: register cycle, selected by adr[1:0]:
  - 00 gpio_dir
  - 01 gpio_data (reads return gpio_in)
  - 11 map (7 bits: [6] hsclk_en, [5] rom_map, [4] ram_map, [1:0] clkdiv)
  - 10 reserved: reads 0, writes ignored
- cpu_adr[23]=0: host cycle, unless remapped as below.

Remaps (cpu_adr[23]=0 only). A remapped access becomes a RAM cycle with bank 0xFE (ram_adr = 0xFE truncated to width):
- ram_map=1 and adr[15]=0.
- rom_map=1 and adr[15:14]=11 and adr[13:10]≠1111.
- rom_map=1 and adr[15:14]=10 and pagereg=1111.

Page register:
- A host write to 0x00FE30 updates the 4-bit pagereg from cpu_wdata[3:0] in the same cycle as its ack.
- The write still runs on the host bus.

State machine, states IDLE, RAM, REG, H_WAIT, H_HIGH:
- IDLE to RAM or REG on decode. Both take 1 cycle, then ack and return to IDLE.
- IDLE to H_WAIT on a host decode.
- H_WAIT to H_HIGH on a synchronised phi0 rising edge.
- H_HIGH to IDLE on a synchronised phi0 falling edge, with ack.
- Host cycles never start mid-phase.

During RAM:
- ram_ceb=0, ram_web=cpu_rnw.
- cpu_rdata is not driven by this block; RAM drives the external bus.

During H_WAIT and H_HIGH:
- bbc_adr = cpu_adr[15:0], bbc_rnw = cpu_rnw.
- bbc_data_oe = !cpu_rnw, asserted in H_HIGH only.

Read capture: bbc_data_in is registered every cycle in H_HIGH. cpu_rdata takes the last sample.

Outside host states: bbc_adr=0x8000, bbc_rnw=1, bbc_data_oe=0 (dummy read).

IO holdoff pipe:
- A host access with adr[15:10]=111111 loads all ones at its ack.
- Otherwise the pipe shifts right by one at each ack.
- cpu_hs_ok = map[6] & (pipe==0), registered.

## Timing
Reset (resetb=0 at a rising edge) clears:
- state to IDLE, map, pagereg, gpio_dir, gpio_data, holdoff pipe, and the synchroniser.

Resulting output values:
- cpu_ack=0, cpu_rdata=0, cpu_hs_ok=0
- ram_ceb=1, ram_web=1, ram_adr=0
- bbc_adr=0x8000, bbc_rnw=1, bbc_data_oe=0, bbc_data_out=0
- gpio_oe=0, gpio_out=0

Reset asserted mid host cycle aborts it with no ack. bbc_data_oe drops on the next edge.

Latency:
- RAM and REG: ack 2 edges after cpu_req is seen in IDLE.
- Host: edge detection lags bbc_phi0 by PHI0_SYNC_STAGES+1 hsclk cycles. Ack lands that long after the phi0 fall.

Register writes take effect in the ack cycle. A read of map in the following request returns the new value.

Back-to-back requests: cpu_req held high after ack is treated as a new request in IDLE on the next cycle.

## Test plan
- Reset → all outputs at the listed reset values. Write map=0x40 → cpu_hs_ok=1 two cycles later.
- RAM read at 0xC12345 → ram_ceb low for exactly 1 cycle, ram_adr=3'b001, ack 2 cycles after request.
- Host read 0x001234, phi0 period 32 hsclk, bbc_data_in=0x5A during the high phase → bbc_adr=0x1234 from H_WAIT, cpu_rdata=0x5A, exactly one ack after the phi0 fall.
- map=0x30, pagereg written 0xF via 0xFE30. Then:
  - read 0x008000 → RAM bank 0xFE
  - read 0x00FC00 → host cycle
  - read 0x001000 → RAM bank 0xFE
- map=0x40, host read 0x00FE40 → cpu_hs_ok=0 until 3 further acks, then 1.
- gpio_dir=0x1, gpio_data=0x3 → gpio_oe=01, gpio_out=11. Read gpio_data with gpio_in=10 → returns 0x02.
